// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path.
//   REG_AW     : register-number width
//   REG_DW     : register data width
//   REG_ZERO   : hard-wired zero register; writes to it are dropped
//   wb_entry_t : one queued writeback {wn, wd}
package regfile_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] wn;
    logic [REG_DW-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: DEPTH-entry synchronous FIFO holding writeback entries for one source.
// Ports:
//   clock, reset : clock, asynchronous active-high reset (clears pointers/count)
//   i_push/i_din : enqueue i_din at the rising edge (caller guarantees !o_full)
//   i_pop        : dequeue head at the rising edge (caller guarantees !o_empty)
//   o_full       : count == DEPTH, from registered count only
//   o_empty      : count == 0
//   o_head       : oldest entry
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      i_push,
  input  wb_entry_t i_din,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_empty,
  output wb_entry_t o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  wb_entry_t     r_mem [DEPTH];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Storage carries data only; validity is tracked by r_count.
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port among NREQ writeback
// sources. Each source feeds a private wb_fifo; a round-robin arbiter drains one
// entry per cycle into registered WN/WD/RegWrite. Register-0 writes are consumed
// without raising RegWrite.
// Ports:
//   clock, reset       : clock, asynchronous active-high reset
//   req_valid[i]       : source i offers {req_wn slice, req_wd slice}
//   req_wn / req_wd    : packed per-source reg number / data, slice i*AW / i*DW
//   req_ready[i]       : FIFO i not full (registered state only)
//   WN, WD, RegWrite   : registered register-file write port
//   grant_id           : source whose entry is on WN/WD
//   idle               : all FIFOs empty and no write in progress
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int DEPTH = 2,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_wn,
  input  logic [NREQ*DW-1:0] req_wd,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      WN,
  output logic [DW-1:0]      WD,
  output logic               RegWrite,
  output logic [1:0]         grant_id,
  output logic               idle
);

  logic [NREQ-1:0] w_push;
  logic [NREQ-1:0] w_pop;
  logic [NREQ-1:0] w_full;
  logic [NREQ-1:0] w_empty;
  wb_entry_t       w_head [NREQ];

  logic [1:0] r_rr_ptr;
  logic       w_found;
  logic [1:0] w_winner;
  logic [1:0] w_idx;
  logic [1:0] w_rr_next;
  wb_entry_t  w_sel;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
    wb_entry_t w_din;
    assign w_din.wn = req_wn[gi*AW +: AW];
    assign w_din.wd = req_wd[gi*DW +: DW];

    // Ready comes from the registered count only; a pop in the same cycle
    // does not reopen a full FIFO.
    assign req_ready[gi] = ~w_full[gi] & ~reset;
    assign w_push[gi]    = req_valid[gi] & req_ready[gi];
    assign w_pop[gi]     = w_found & (w_winner == 2'(gi));

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push[gi]),
      .i_din   (w_din),
      .i_pop   (w_pop[gi]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi]),
      .o_head  (w_head[gi])
    );
  end

  // Scan rr_ptr, rr_ptr+1, ... (mod NREQ); the first nonempty source wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = 2'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_found && !w_empty[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_rr_next = 2'((int'(w_winner) + 1) % NREQ);
  assign w_sel     = w_head[w_winner];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      WN       <= '0;
      WD       <= '0;
      RegWrite <= 1'b0;
      grant_id <= '0;
    end else if (w_found) begin
      r_rr_ptr <= w_rr_next;
      WN       <= w_sel.wn;
      WD       <= w_sel.wd;
      grant_id <= w_winner;
      // Register-0 entries use their slot but never strobe the register file.
      RegWrite <= (w_sel.wn != REG_ZERO);
    end else begin
      RegWrite <= 1'b0;
    end
  end

  assign idle = (&w_empty) & ~RegWrite;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_wn;
  logic [NREQ*DW-1:0] req_wd;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      WN;
  logic [DW-1:0]      WD;
  logic               RegWrite;
  logic [1:0]         grant_id;
  logic               idle;

  regfile_wb_arbiter #(.NREQ(NREQ), .DEPTH(2), .AW(AW), .DW(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_wn    (req_wn),
    .req_wd    (req_wd),
    .req_ready (req_ready),
    .WN        (WN),
    .WD        (WD),
    .RegWrite  (RegWrite),
    .grant_id  (grant_id),
    .idle      (idle)
  );

  always #5 clock = ~clock;

  int        total = 0;
  int        bad = 0;
  int        nwrites = 0;
  int        maxwait = 0;
  int        waitc [NREQ];
  bit        track_wait = 1'b0;
  wb_entry_t sb [NREQ][$];
  wb_entry_t s_ent;
  wb_entry_t m_ent;
  int        m_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [AW-1:0] wn, input logic [DW-1:0] wd);
    req_valid[i]       = v;
    req_wn[i*AW +: AW] = wn;
    req_wd[i*DW +: DW] = wd;
  endtask

  // Scoreboard push: every accepted handshake is expected later on the write port.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          s_ent.wn = req_wn[i*AW +: AW];
          s_ent.wd = req_wd[i*DW +: DW];
          sb[i].push_back(s_ent);
        end
      end
    end
  end

  // Scoreboard pop: each RegWrite must match the oldest outstanding nonzero entry of its source.
  always @(negedge clock) begin
    if (!reset) begin
      m_g = int'(grant_id);
      if (RegWrite) begin
        nwrites++;
        while (sb[m_g].size() > 0 && sb[m_g][0].wn == REG_ZERO) m_ent = sb[m_g].pop_front();
        if (sb[m_g].size() == 0) begin
          chk("sb_has_entry", 64'd0, 64'd1);
        end else begin
          m_ent = sb[m_g].pop_front();
          chk("sb_wn", 64'(WN), 64'(m_ent.wn));
          chk("sb_wd", 64'(WD), 64'(m_ent.wd));
        end
      end
      if (track_wait) begin
        for (int i = 0; i < NREQ; i++) begin
          if (RegWrite && m_g == i) waitc[i] = 0;
          else if (sb[i].size() > 0) begin
            waitc[i]++;
            if (waitc[i] > maxwait) maxwait = waitc[i];
          end else waitc[i] = 0;
        end
      end
    end
  end

  initial begin
    req_valid = '0;
    req_wn    = '0;
    req_wd    = '0;
    for (int i = 0; i < NREQ; i++) waitc[i] = 0;

    // Reset state
    #1;
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_wn", 64'(WN), 64'd0);
    chk("rst_wd", 64'(WD), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_ready", 64'(req_ready), 64'd0);
    @(posedge clock);
    #3 reset = 1'b0;
    step();
    chk("post_rst_ready", 64'(req_ready), 64'h7);

    // Reset mid-stream
    drive(0, 1'b1, 5'd1, 32'h11);
    drive(1, 1'b1, 5'd2, 32'h22);
    drive(2, 1'b1, 5'd3, 32'h33);
    step();
    drive(0, 1'b1, 5'd4, 32'h44);
    drive(1, 1'b1, 5'd5, 32'h55);
    drive(2, 1'b1, 5'd6, 32'h66);
    step();
    req_valid = '0;
    chk("mid_regwrite_before", 64'(RegWrite), 64'd1);
    chk("mid_wn_before", 64'(WN), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_regwrite_async", 64'(RegWrite), 64'd0);
    chk("mid_wn_async", 64'(WN), 64'd0);
    chk("mid_idle_async", 64'(idle), 64'd1);
    chk("mid_ready_async", 64'(req_ready), 64'd0);
    for (int i = 0; i < NREQ; i++) sb[i].delete();
    step();
    #2 reset = 1'b0;
    step();
    chk("mid_idle_after", 64'(idle), 64'd1);
    chk("mid_nowrite_1", 64'(RegWrite), 64'd0);
    step();
    chk("mid_nowrite_2", 64'(RegWrite), 64'd0);
    chk("mid_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);

    // Contention: all three at one edge
    drive(0, 1'b1, 5'd3, 32'h300);
    drive(1, 1'b1, 5'd4, 32'h400);
    drive(2, 1'b1, 5'd5, 32'h500);
    step();
    req_valid = '0;
    chk("cont_lat0", 64'(RegWrite), 64'd0);
    step();
    chk("cont_g0", 64'(grant_id), 64'd0);
    chk("cont_wn0", 64'(WN), 64'd3);
    chk("cont_we0", 64'(RegWrite), 64'd1);
    step();
    chk("cont_g1", 64'(grant_id), 64'd1);
    chk("cont_wn1", 64'(WN), 64'd4);
    step();
    chk("cont_g2", 64'(grant_id), 64'd2);
    chk("cont_wn2", 64'(WN), 64'd5);
    step();
    chk("cont_done", 64'(RegWrite), 64'd0);
    chk("cont_idle", 64'(idle), 64'd1);
    chk("cont_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);

    // Backpressure on source 1
    drive(0, 1'b1, 5'd10, 32'hA0);
    drive(1, 1'b1, 5'd11, 32'hB0);
    chk("bp_ready_e0", 64'(req_ready[1]), 64'd1);
    step();
    drive(0, 1'b1, 5'd12, 32'hA1);
    drive(1, 1'b1, 5'd13, 32'hB1);
    chk("bp_ready_e1", 64'(req_ready[1]), 64'd1);
    step();
    chk("bp_full_ready", 64'(req_ready[1]), 64'd0);
    chk("bp_wn_e1", 64'(WN), 64'd10);
    chk("bp_g_e1", 64'(grant_id), 64'd0);
    drive(0, 1'b1, 5'd14, 32'hA2);
    drive(1, 1'b1, 5'd15, 32'hB2);
    step();
    chk("bp_wn_e2", 64'(WN), 64'd11);
    chk("bp_g_e2", 64'(grant_id), 64'd1);
    chk("bp_ready_reopen", 64'(req_ready[1]), 64'd1);
    drive(0, 1'b0, 5'd0, 32'h0);
    step();
    chk("bp_wn_e3", 64'(WN), 64'd12);
    drive(1, 1'b0, 5'd0, 32'h0);
    step();
    chk("bp_wn_e4", 64'(WN), 64'd13);
    step();
    chk("bp_wn_e5", 64'(WN), 64'd14);
    step();
    chk("bp_wn_e6", 64'(WN), 64'd15);
    chk("bp_wd_e6", 64'(WD), 64'hB2);
    chk("bp_g_e6", 64'(grant_id), 64'd1);
    step();
    chk("bp_done", 64'(RegWrite), 64'd0);

    // Single source streaming
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, 5'(i + 1), 32'((i + 1) * 16));
      chk("ss_ready", 64'(req_ready[0]), 64'd1);
      step();
      if (i == 0) chk("ss_lat", 64'(RegWrite), 64'd0);
      else begin
        chk("ss_we", 64'(RegWrite), 64'd1);
        chk("ss_wn", 64'(WN), 64'(i));
      end
    end
    drive(0, 1'b0, 5'd0, 32'h0);
    step();
    chk("ss_last_we", 64'(RegWrite), 64'd1);
    chk("ss_last_wn", 64'(WN), 64'd8);
    chk("ss_last_wd", 64'(WD), 64'd128);
    step();
    chk("ss_end", 64'(RegWrite), 64'd0);

    // Register zero
    drive(2, 1'b1, 5'd0, 32'hDEAD_BEEF);
    step();
    drive(2, 1'b1, 5'd7, 32'h77);
    step();
    drive(2, 1'b0, 5'd0, 32'h0);
    chk("r0_grant", 64'(grant_id), 64'd2);
    chk("r0_we", 64'(RegWrite), 64'd0);
    chk("r0_not_idle", 64'(idle), 64'd0);
    step();
    chk("r0_next_we", 64'(RegWrite), 64'd1);
    chk("r0_next_wn", 64'(WN), 64'd7);
    chk("r0_next_wd", 64'(WD), 64'h77);
    step();
    chk("r0_idle", 64'(idle), 64'd1);

    // Random soak
    track_wait = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < NREQ; i++)
        drive(i, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), 32'($urandom));
      step();
    end
    req_valid = '0;
    repeat (10) step();
    track_wait = 1'b0;
    for (int i = 0; i < NREQ; i++) chk("soak_drained", 64'(sb[i].size()), 64'd0);
    chk("soak_max_wait", 64'(maxwait <= NREQ), 64'd1);
    chk("soak_idle", 64'(idle), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
